cpu_control_seq: RTL

Parametrised multi-cycle control sequencer for the accumulator CPU. It replaces the fixed 4-state fetch/decode/execute/writeback controller with a handshaked version. Instruction and data memory accesses use req/ack with variable latency and a wait-timeout watchdog. The block adds halt/resume, a sticky trap on illegal opcode or timeout, and a retired-instruction counter. It sits between the IR/PC/accumulator datapath and the two memories.

---
 rtl/cpu_control_seq_if.sv | 34 +++
 rtl/cpu_control_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_seq_if.sv
// ---------------------------------------------------------------------------
// cpu_control_seq_if
// Memory handshake bundle between the control sequencer and the instruction
// and data memories.
//   imem_req : sequencer -> imem, instruction fetch request
//   imem_ack : imem -> sequencer, instruction data valid
//   dmem_req : sequencer -> dmem, data access request
//   dmem_we  : sequencer -> dmem, write qualifier (only with dmem_req)
//   dmem_ack : dmem -> sequencer, data access complete
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface cpu_control_seq_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_control_seq.sv
// ---------------------------------------------------------------------------
// cpu_control_seq
// Multi-cycle handshaked control sequencer for the accumulator CPU.
// Walks FETCH -> DECODE -> EXEC -> (WB) per instruction, talks to the
// instruction and data memories with req/ack, traps on illegal opcodes or on
// a memory that does not answer within WAIT_MAX cycles, supports halt/resume
// and counts retired instructions.
//
// Parameters:
//   OPCODE_W : opcode width (>= 3); any code >= 8 is illegal
//   WAIT_MAX : cycles a request may wait for its ack before trapping (>= 1)
//   CNT_W    : retired-instruction counter width (wraps)
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   mem             : memory handshake bundle (master side)
//   i_opcode        : current IR opcode, stable DECODE..WB
//   i_is_zero       : accumulator == 0
//   i_resume        : leave HALTED (level)
//   i_step          : single-step from HALTED (only with CPU_CONTROL_STEP_EN)
//   o_ir_load       : capture instruction into IR
//   o_pc_en         : PC increment
//   o_pc_load       : PC load from IR operand
//   o_acc_load      : accumulator write enable
//   o_acc_sel       : 0 = ALU result, 1 = memory data
//   o_halted        : sequencer in HALTED
//   o_trap          : sticky fault flag
//   o_trap_cause    : 00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
//   o_retired       : instructions completed
//
// Optional feature macro: CPU_CONTROL_STEP_EN (adds i_step single-stepping).
// Strobes are combinational on state/opcode/is_zero/ack; state, wait
// counter, trap cause and retired count are registered.
// ---------------------------------------------------------------------------
module cpu_control_seq #(
  parameter int OPCODE_W = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  cpu_control_seq_if.master   mem,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_is_zero,
  input  logic                i_resume,
`ifdef CPU_CONTROL_STEP_EN
  input  logic                i_step,
`endif
  output logic                o_ir_load,
  output logic                o_pc_en,
  output logic                o_pc_load,
  output logic                o_acc_load,
  output logic                o_acc_sel,
  output logic                o_halted,
  output logic                o_trap,
  output logic [1:0]          o_trap_cause,
  output logic [CNT_W-1:0]    o_retired
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    RST_S  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // Opcodes that write the accumulator in WB.
  function automatic logic op_writes_acc(input logic [2:0] op);
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: op_writes_acc = 1'b1;
      default:                        op_writes_acc = 1'b0;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_done_state;
  logic [WCNT_W-1:0]  r_wait;
  logic [WCNT_W-1:0]  w_wait_nxt;
  logic [WCNT_W-1:0]  w_wait_inc;
  logic               w_wait_hit;
  logic [1:0]         r_cause;
  logic [1:0]         w_cause_nxt;
  logic [CNT_W-1:0]   r_retired;
  logic               w_retire;
  logic [2:0]         w_op;
  logic               w_illegal;
  logic               w_step_req;
  logic               w_step_mode;

  logic w_imem_req;
  logic w_ir_load;
  logic w_pc_en;
  logic w_pc_load;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_acc_load;
  logic w_acc_sel;
  logic w_halted;
  logic w_trap;

  assign w_op = i_opcode[2:0];

  // Any set bit above the low three opcode bits means code >= 8.
  if (OPCODE_W > 3) begin : g_wide_op
    assign w_illegal = |i_opcode[OPCODE_W-1:3];
  end else begin : g_narrow_op
    assign w_illegal = 1'b0;
  end

  // The counter value after this cycle's wait; reaching WAIT_MAX without
  // an ack is the timeout. An ack in that same cycle takes precedence.
  assign w_wait_inc = r_wait + WCNT_W'(1);
  assign w_wait_hit = (w_wait_inc == WCNT_W'(WAIT_MAX));

`ifdef CPU_CONTROL_STEP_EN
  logic r_step;

  assign w_step_req  = i_step;
  assign w_step_mode = r_step;

  // Remembers that the instruction in flight was launched by a step, so it
  // returns to HALTED; only re-evaluated while sitting in HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 1'b0;
    end else if (r_state == HALTED) begin
      r_step <= i_step & ~i_resume;
    end else begin
      r_step <= r_step;
    end
  end
`else
  assign w_step_req  = 1'b0;
  assign w_step_mode = 1'b0;
`endif

  // Where a completed instruction goes: back to fetch, or back to HALTED
  // when it was a single step.
  assign w_done_state = w_step_mode ? HALTED : FETCH;

  // State, wait counter, trap cause and retired count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RST_S;
      r_wait    <= '0;
      r_cause   <= 2'b00;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_cause <= w_cause_nxt;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Next-state, wait counter, trap cause and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    w_cause_nxt = r_cause;
    w_retire    = 1'b0;
    w_imem_req  = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_en     = 1'b0;
    w_pc_load   = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_acc_load  = 1'b0;
    w_acc_sel   = 1'b0;
    w_halted    = 1'b0;
    w_trap      = 1'b0;

    case (r_state)
      RST_S: begin
        w_state_nxt = FETCH;
      end

      FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = DECODE;
        end else if (w_wait_hit) begin
          w_state_nxt = TRAP;
          w_cause_nxt = CAUSE_IMEM;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end

      DECODE: begin
        if (w_illegal) begin
          w_state_nxt = TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end else begin
          case (w_op)
            OP_HLT: begin
              w_pc_en     = 1'b1;
              w_retire    = 1'b1;
              w_state_nxt = HALTED;
            end
            OP_JMP: begin
              w_pc_load   = 1'b1;
              w_state_nxt = EXEC;
            end
            default: begin
              w_pc_en     = 1'b1;
              w_state_nxt = EXEC;
            end
          endcase
        end
      end

      EXEC: begin
        case (w_op)
          OP_SKZ: begin
            // Second PC increment skips the next instruction.
            w_pc_en     = i_is_zero;
            w_retire    = 1'b1;
            w_state_nxt = w_done_state;
          end
          OP_JMP: begin
            w_retire    = 1'b1;
            w_state_nxt = w_done_state;
          end
          OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (w_op == OP_STO);
            if (mem.dmem_ack) begin
              w_state_nxt = WB;
            end else if (w_wait_hit) begin
              w_state_nxt = TRAP;
              w_cause_nxt = CAUSE_DMEM;
            end else begin
              w_wait_nxt = w_wait_inc;
            end
          end
          default: begin
            w_state_nxt = FETCH;
          end
        endcase
      end

      WB: begin
        w_acc_load  = op_writes_acc(w_op);
        w_acc_sel   = (w_op == OP_LDA);
        w_retire    = 1'b1;
        w_state_nxt = w_done_state;
      end

      HALTED: begin
        w_halted = 1'b1;
        if (i_resume) begin
          w_state_nxt = FETCH;
        end else if (w_step_req) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = HALTED;
        end
      end

      TRAP: begin
        // Sticky: only rst leaves this state.
        w_trap      = 1'b1;
        w_state_nxt = TRAP;
      end

      default: begin
        w_state_nxt = RST_S;
      end
    endcase
  end

  assign mem.imem_req = w_imem_req;
  assign mem.dmem_req = w_dmem_req;
  assign mem.dmem_we  = w_dmem_we;
  assign o_ir_load    = w_ir_load;
  assign o_pc_en      = w_pc_en;
  assign o_pc_load    = w_pc_load;
  assign o_acc_load   = w_acc_load;
  assign o_acc_sel    = w_acc_sel;
  assign o_halted     = w_halted;
  assign o_trap       = w_trap;
  assign o_trap_cause = r_cause;
  assign o_retired    = r_retired;

endmodule
